// File: rtl/regsched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regsched_pkg;

  localparam int unsigned REG_NO_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_RD   = 3;

  typedef struct packed {
    logic [REG_NO_W-1:0] no;
    logic [DATA_W-1:0]   data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    SRC_EX  = 2'd0,
    SRC_LD  = 2'd1,
    SRC_DBG = 2'd2
  } src_e;

endpackage

// File: rtl/regfile_write_sched_if.sv
// Core-side bundle: three read ports with stall, plus the three writeback handshakes.
interface regfile_write_sched_if;
  import regsched_pkg::*;

  logic                rd_req;
  logic [REG_NO_W-1:0] rd_a_no;
  logic [REG_NO_W-1:0] rd_b_no;
  logic [REG_NO_W-1:0] rd_c_no;
  logic [DATA_W-1:0]   rd_a_data;
  logic [DATA_W-1:0]   rd_b_data;
  logic [DATA_W-1:0]   rd_c_data;
  logic                rd_stall;

  logic                ex_valid;
  logic                ex_ready;
  logic [REG_NO_W-1:0] ex_no;
  logic [DATA_W-1:0]   ex_data;
  logic                ld_valid;
  logic                ld_ready;
  logic [REG_NO_W-1:0] ld_no;
  logic [DATA_W-1:0]   ld_data;
  logic                dbg_valid;
  logic                dbg_ready;
  logic [REG_NO_W-1:0] dbg_no;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output rd_req, rd_a_no, rd_b_no, rd_c_no,
    output ex_valid, ex_no, ex_data, ld_valid, ld_no, ld_data, dbg_valid, dbg_no, dbg_data,
    input  rd_a_data, rd_b_data, rd_c_data, rd_stall, ex_ready, ld_ready, dbg_ready
  );

  modport slave (
    input  rd_req, rd_a_no, rd_b_no, rd_c_no,
    input  ex_valid, ex_no, ex_data, ld_valid, ld_no, ld_data, dbg_valid, dbg_no, dbg_data,
    output rd_a_data, rd_b_data, rd_c_data, rd_stall, ex_ready, ld_ready, dbg_ready
  );

endinterface

// File: rtl/regsched_wq.sv
// Shift-style write queue (slot 0 is the oldest) with youngest-match lookup per read port.
module regsched_wq
  import regsched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  wq_entry_t                        push_entry_i,
  input  logic                             pop_i,
  input  logic [NUM_RD-1:0][REG_NO_W-1:0]  lookup_no_i,
  output logic [2:0]                       count_o,
  output wq_entry_t                        head_o,
  output logic [NUM_RD-1:0]                hit_o,
  output logic [NUM_RD-1:0][DATA_W-1:0]    hit_data_o
);

  wq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [2:0]            count_q, count_d;

  // Later slots are younger, so the last match in slot order wins.
  function automatic logic [DATA_W:0] youngest_match(input logic [REG_NO_W-1:0] no,
                                                     input wq_entry_t [DEPTH-1:0] mem,
                                                     input logic [2:0] cnt);
    logic [DATA_W:0] res;
    res = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (3'(i) < cnt && mem[i].no == no) res = {1'b1, mem[i].data};
    end
    return res;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop_i) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) mem_d[i] = mem_q[i + 1];
      count_d = count_q - 3'd1;
    end
    if (push_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (3'(i) == count_d) mem_d[i] = push_entry_i;
      end
      count_d = count_d + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_RD); p++) begin
      {hit_o[p], hit_data_o[p]} = youngest_match(lookup_no_i[p], mem_q, count_q);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];

endmodule

// File: rtl/regfile_write_sched.sv
// Write scheduler for a register file whose write port shares its address with read port A.
// Build option REGSCHED_BYPASS_EN: forward queued data to reads instead of stalling until drained.
module regfile_write_sched
  import regsched_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  regfile_write_sched_if.slave  bus_io,
  output logic                  rf_wr_o,
  output logic [REG_NO_W-1:0]   rf_rno0_o,
  output logic [REG_NO_W-1:0]   rf_rno1_o,
  output logic [REG_NO_W-1:0]   rf_rno2_o,
  output logic [DATA_W-1:0]     rf_din_o,
  input  logic [DATA_W-1:0]     rf_dout0_i,
  input  logic [DATA_W-1:0]     rf_dout1_i,
  input  logic [DATA_W-1:0]     rf_dout2_i,
  output logic [2:0]            wq_count_o
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [2:0]                      count;
  wq_entry_t                       head;
  wq_entry_t                       push_entry;
  logic [NUM_RD-1:0]               hit;
  logic [NUM_RD-1:0][DATA_W-1:0]   hit_data;
  logic [NUM_RD-1:0][REG_NO_W-1:0] lookup_no;
  logic                            full, nonempty, push, write_go, hazard_drain;
  src_e                            grant;
  logic [StarveW-1:0]              starve_q, starve_d;

  assign full     = (count == 3'(DEPTH));
  assign nonempty = (count != 3'd0);

  // Grant is derived from the registered count, so a pop never opens a slot in the same cycle.
  always_comb begin
    bus_io.ex_ready  = ~full;
    bus_io.ld_ready  = ~full & ~bus_io.ex_valid;
    bus_io.dbg_ready = ~full & ~bus_io.ex_valid & ~bus_io.ld_valid;
    push = ~full & (bus_io.ex_valid | bus_io.ld_valid | bus_io.dbg_valid);
    if (bus_io.ex_valid)      grant = SRC_EX;
    else if (bus_io.ld_valid) grant = SRC_LD;
    else                      grant = SRC_DBG;
    unique case (grant)
      SRC_EX:  push_entry = '{no: bus_io.ex_no, data: bus_io.ex_data};
      SRC_LD:  push_entry = '{no: bus_io.ld_no, data: bus_io.ld_data};
      default: push_entry = '{no: bus_io.dbg_no, data: bus_io.dbg_data};
    endcase
  end

  assign lookup_no = {bus_io.rd_c_no, bus_io.rd_b_no, bus_io.rd_a_no};

  regsched_wq #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (write_go),
    .lookup_no_i  (lookup_no),
    .count_o      (count),
    .head_o       (head),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

`ifdef REGSCHED_BYPASS_EN
  assign hazard_drain     = 1'b0;
  assign bus_io.rd_a_data = hit[0] ? hit_data[0] : rf_dout0_i;
  assign bus_io.rd_b_data = hit[1] ? hit_data[1] : rf_dout1_i;
  assign bus_io.rd_c_data = hit[2] ? hit_data[2] : rf_dout2_i;
`else
  logic unused_fwd_data;
  // Any read touching a queued register waits until those writes reach the RAM.
  assign hazard_drain     = bus_io.rd_req & (|hit);
  assign unused_fwd_data  = ^hit_data;
  assign bus_io.rd_a_data = rf_dout0_i;
  assign bus_io.rd_b_data = rf_dout1_i;
  assign bus_io.rd_c_data = rf_dout2_i;
`endif

  assign write_go = nonempty & (~bus_io.rd_req | full |
                                (starve_q == StarveW'(STARVE_MAX)) | hazard_drain);
  assign bus_io.rd_stall = bus_io.rd_req & (write_go | hazard_drain);

  always_comb begin
    starve_d = starve_q;
    if (!nonempty || write_go) begin
      starve_d = '0;
    end else if (bus_io.rd_req && starve_q != StarveW'(STARVE_MAX)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign rf_wr_o    = write_go;
  assign rf_rno0_o  = write_go ? head.no : bus_io.rd_a_no;
  assign rf_rno1_o  = bus_io.rd_b_no;
  assign rf_rno2_o  = bus_io.rd_c_no;
  assign rf_din_o   = head.data;
  assign wq_count_o = count;

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
Sequences the triple-port register file, where write address and read port A share one address input (rno0). Buffers writeback requests from three sources in a small write queue and arbitrates rno0 between core reads and queued writes, stalling the core when a write takes the port. Forwards pending write data to all three read ports, so reads never return stale values. Sits between the RISC5 core's decode/writeback stages and the register-file instance.

Parameters:
DEPTH, 2, write-queue entries (2..4)
STARVE_MAX, 4, consecutive deferred-write cycles before a write is forced

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rd_req  in  1  core requests a read this cycle
rd_a_no  in  4  read port A register number
rd_b_no  in  4  read port B register number
rd_c_no  in  4  read port C register number
rd_a_data  out  32  port A data, after forwarding
rd_b_data  out  32  port B data, after forwarding
rd_c_data  out  32  port C data, after forwarding
rd_stall  out  1  read not serviced this cycle; core holds and retries
ex_valid/ex_ready  in/out  1  execute writeback handshake
ex_no  in  4  execute writeback register number
ex_data  in  32  execute writeback data
ld_valid/ld_ready  in/out  1  load writeback handshake
ld_no  in  4  load writeback register number
ld_data  in  32  load writeback data
dbg_valid/dbg_ready  in/out  1  debug write handshake
dbg_no  in  4  debug write register number
dbg_data  in  32  debug write data
rf_wr  out  1  register-file write enable
rf_rno0  out  4  register-file shared write/read-A address
rf_rno1  out  4  register-file read-B address
rf_rno2  out  4  register-file read-C address
rf_din  out  32  register-file write data
rf_dout0  in  32  register-file read-A data
rf_dout1  in  32  register-file read-B data
rf_dout2  in  32  register-file read-C data
wq_count  out  3  current queue occupancy

Behaviour:
- Reset (rst=0, async): queue empty, wq_count=0, starve counter=0. Combinationally this yields rf_wr=0, rd_stall=0 and all readys=1. Register-file contents are not cleared.
- Enqueue: at most one per cycle, fixed priority ex > ld > dbg. Only the granted source sees ready=1. All readys are 0 when count==DEPTH. The grant is taken from the registered count, so no enqueue-on-dequeue fallthrough into a full queue.
- Dequeue decision (combinational) is write_go = nonempty & (~rd_req | count==DEPTH | starve==STARVE_MAX | hazard_drain). hazard_drain is 0 when bypass is enabled.
- When write_go=1:
  - rf_wr=1, rf_rno0=head.no, rf_din=head.data; the head pops at the clock edge.
  - rd_stall=rd_req.
- When write_go=0: rf_wr=0, rf_rno0=rd_a_no.
- rf_rno1=rd_b_no and rf_rno2=rd_c_no always.
- Starve counter:
  - increments when nonempty & rd_req & ~write_go;
  - clears on any write or when the queue is empty;
  - saturates at STARVE_MAX.
- Forwarding: each read port returns data from the youngest queue entry whose no matches; otherwise it returns rf_doutN. The entry being written this cycle is still in the queue and is forwarded.
- A same-cycle enqueue is not visible to reads until the next cycle.
- Simultaneous enqueue+dequeue: count is unchanged and FIFO order is preserved. Duplicate register numbers in the queue are legal; the youngest wins on forwarding, and oldest-first draining gives correct final RAM contents.
- A reset mid-operation discards all queued writes.

Optional Feature:
REGSCHED_BYPASS_EN.
- Defined: forwarding as above; hazard_drain=0.
- Undefined: no forwarding, and rd_x_data=rf_doutN. If rd_req and any of rd_a/b/c_no matches a queue entry:
  - hazard_drain=1 and rd_stall=1, even on a cycle without a write;
  - the queue drains until no match remains.

Decomposition:
- Shared package regsched_pkg holds:
  - typedef wq_entry_t {no[3:0], data[31:0]};
  - constants REG_NO_W=4 and DATA_W=32;
  - source-index enum SRC_EX/SRC_LD/SRC_DBG.
- Sub-module regsched_wq: DEPTH-entry FIFO with count, head outputs and a per-entry match/youngest-select function used by all three read ports.

Test Plan:
1. Reset, then ex write R3=0x12345678 with rd_req=0 -> enqueued at cycle 1; cycle 2 rf_wr=1, rf_rno0=3, rf_din=0x12345678; count returns to 0.
2. Continuous rd_req with rd_a_no=5 while ld writes R7=0xA5A5A5A5 -> write deferred 4 cycles, forced on cycle 5 with rd_stall=1, rf_rno0=7.
3. ex, ld and dbg valid together -> ex_ready=1 only; ld is granted next cycle, then dbg. The three writes drain in order ex, ld, dbg.
4. Queue full (DEPTH=2) with rd_req=1 -> all readys=0, write_go=1, rd_stall=1; count goes 2→1 and ex_ready returns next cycle.
5. With BYPASS_EN: queue R4=0x1 then R4=0x2, read rd_b_no=4 -> rd_b_data=0x2 before the RAM is written; after drain, RAM R4=0x2.
6. Without BYPASS_EN: same as scenario 5 -> rd_stall=1 until both entries drain, then rd_b_data=0x2 from RAM.
